// File: rtl/sample_ram_arbiter.sv
// Round-robin arbiter sharing one sample RAM read port between left and right codec channels.
// Each channel owns a looping read pointer, a pending flag and a sticky overrun flag.
module sample_ram_arbiter #(
   parameter int ADDR_WIDTH = 15,
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clock_i,
   input  logic                  reset_i,
   input  logic                  enable_i,
   input  logic                  cfg_load_i,
   input  logic [ADDR_WIDTH-1:0] loop_start_i,
   input  logic [ADDR_WIDTH-1:0] loop_end_i,
   input  logic                  l_req_i,
   input  logic                  r_req_i,
   input  logic [DATA_WIDTH-1:0] ram_data_i,
   output logic [ADDR_WIDTH-1:0] ram_addr_o,
   output logic                  ram_rd_en_o,
   output logic [DATA_WIDTH-1:0] l_data_o,
   output logic [DATA_WIDTH-1:0] r_data_o,
   output logic                  l_valid_o,
   output logic                  r_valid_o,
   output logic                  l_overrun_o,
   output logic                  r_overrun_o,
   output logic                  busy_o
);

   localparam logic CH_L = 1'b0;
   localparam logic CH_R = 1'b1;

   typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE} state_t;

   state_t                state_q, state_d;
   logic [1:0]            req, pend_eff, avail, grant_oh;
   logic [1:0]            pend_q, pend_d;
   logic [1:0]            ovr_q, ovr_d;
   logic [1:0]            valid_q, valid_d;
   logic [ADDR_WIDTH-1:0] ptr_q [2];
   logic [ADDR_WIDTH-1:0] ptr_d [2];
   logic [DATA_WIDTH-1:0] data_q [2];
   logic [DATA_WIDTH-1:0] data_d [2];
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic                  gnt_q, gnt_d;
   logic                  last_q, last_d;
   logic                  suppress_q, suppress_d;
   logic                  do_grant, gnt_sel;

   function automatic logic [ADDR_WIDTH-1:0] advance(input logic [ADDR_WIDTH-1:0] ptr,
                                                     input logic [ADDR_WIDTH-1:0] lo,
                                                     input logic [ADDR_WIDTH-1:0] hi);
      if (ptr == hi || ptr == '1)
         return lo;
      return ptr + ADDR_WIDTH'(1);
   endfunction

   always_comb begin
      req        = {r_req_i, l_req_i};
      pend_eff   = cfg_load_i ? 2'b00 : pend_q;
      avail      = pend_eff | req;
      gnt_sel    = avail[CH_R] & (~avail[CH_L] | (last_q == CH_L));
      do_grant   = enable_i & (|avail) & (state_q != ISSUE);
      grant_oh   = 2'b00;
      if (do_grant)
         grant_oh[gnt_sel] = 1'b1;

      state_d    = state_q;
      addr_d     = addr_q;
      gnt_d      = gnt_q;
      last_d     = last_q;
      valid_d    = 2'b00;
      data_d     = data_q;
      suppress_d = (state_q == ISSUE) & cfg_load_i;

      // A read in flight when cfg_load arrives keeps its data but must not advance the pointer.
      for (int c = 0; c < 2; c++) begin
         if (cfg_load_i)
            ptr_d[c] = loop_start_i;
         else if (state_q == CAPTURE && gnt_q == 1'(c) && !suppress_q)
            ptr_d[c] = advance(ptr_q[c], loop_start_i, loop_end_i);
         else
            ptr_d[c] = ptr_q[c];

         pend_d[c] = grant_oh[c] ? (req[c] & pend_eff[c]) : avail[c];
         ovr_d[c]  = cfg_load_i ? 1'b0 : (ovr_q[c] | (req[c] & pend_q[c] & ~grant_oh[c]));
      end

      if (state_q == CAPTURE) begin
         data_d[gnt_q]  = ram_data_i;
         valid_d[gnt_q] = 1'b1;
      end

      // The issued address is the pointer value after this cycle's advance/reload.
      if (do_grant) begin
         addr_d = ptr_d[gnt_sel];
         gnt_d  = gnt_sel;
         last_d = gnt_sel;
      end

      case (state_q)
         IDLE:    if (do_grant) state_d = ISSUE;
         ISSUE:   state_d = CAPTURE;
         CAPTURE: state_d = do_grant ? ISSUE : IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         state_q    <= IDLE;
         pend_q     <= 2'b00;
         ovr_q      <= 2'b00;
         valid_q    <= 2'b00;
         ptr_q      <= '{default: '0};
         data_q     <= '{default: '0};
         addr_q     <= '0;
         gnt_q      <= CH_L;
         last_q     <= CH_R;
         suppress_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         pend_q     <= pend_d;
         ovr_q      <= ovr_d;
         valid_q    <= valid_d;
         ptr_q      <= ptr_d;
         data_q     <= data_d;
         addr_q     <= addr_d;
         gnt_q      <= gnt_d;
         last_q     <= last_d;
         suppress_q <= suppress_d;
      end
   end

   assign ram_addr_o  = addr_q;
   assign ram_rd_en_o = (state_q == ISSUE);
   assign busy_o      = (state_q != IDLE);
   assign l_data_o    = data_q[CH_L];
   assign r_data_o    = data_q[CH_R];
   assign l_valid_o   = valid_q[CH_L];
   assign r_valid_o   = valid_q[CH_R];
   assign l_overrun_o = ovr_q[CH_L];
   assign r_overrun_o = ovr_q[CH_R];

endmodule

// File: doc/sample_ram_arbiter.md
# sample_ram_arbiter

Shares the single 8-bit sample RAM read port between the left and right codec channels. Each channel keeps its own 15-bit read pointer that loops over a configurable address window. The block arbitrates per-sample fetch requests round-robin, sequences the one-cycle-latency RAM read and returns each byte with a valid strobe. It sits between the sample RAM and the codec serial interface, replacing free-running address counters.

## Interface
- ADDR_WIDTH, 15, RAM address width.
- DATA_WIDTH, 8, RAM data width.

- clock  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- enable  in  1  1 = grants allowed; 0 = requests still accumulate as pending, no new reads start.
- cfg_load  in  1  one-cycle pulse; reloads both pointers to loop_start.
- loop_start  in  ADDR_WIDTH  first address of the playback window.
- loop_end  in  ADDR_WIDTH  last address of the playback window, inclusive.
- l_req, r_req  in  1  one-cycle fetch request per channel, already synchronous to clock.
- ram_data  in  DATA_WIDTH  RAM read data, valid the cycle after ram_rd_en.
- ram_addr  out  ADDR_WIDTH  registered RAM address.
- ram_rd_en  out  1  RAM read strobe.
- l_data, r_data  out  DATA_WIDTH  last fetched byte per channel, held until the next fetch.
- l_valid, r_valid  out  1  one-cycle strobe when the corresponding data register updates.
- l_overrun, r_overrun  out  1  sticky; set when a request is lost.
- busy  out  1  high whenever the FSM is not in IDLE.

## Operation
- Reset values: all outputs 0, both pointers 0, all pending flags 0, state IDLE, last_grant = R (left wins the first tie).
- Each channel has a pending flag. The flag is set by its req. It is cleared in the cycle the channel is granted. A req arriving in its own grant cycle re-sets the flag.
- A req that arrives while the flag is already set and not yet granted is merged, and the channel's overrun flag is set. Only reset or cfg_load clears overrun.
- FSM states are IDLE, ISSUE and CAPTURE.
  - IDLE → ISSUE when enable = 1 and (pending | req) is non-zero for some channel. A request visible in the same cycle counts.
  - Grant goes to the sole requester. If both are requesting, grant goes to the channel other than last_grant. last_grant updates on every grant.
  - On the IDLE→ISSUE transition, ram_addr is loaded with the granted channel's pointer.
  - ISSUE: ram_rd_en = 1 for exactly this cycle; next state is CAPTURE.
  - CAPTURE: ram_data is registered into the granted channel's data register, and that channel's valid pulses in the following cycle. The pointer then advances.
  - CAPTURE → ISSUE directly if enable = 1 and the other (or the same) channel is pending; the arbitration rule is the same as in IDLE. Otherwise CAPTURE → IDLE.
- Pointer advance: if ptr == loop_end, or ptr == all-ones, the next ptr is loop_start. Otherwise the next ptr is ptr + 1, modulo 2^ADDR_WIDTH.
  - If loop_end < loop_start, wrap occurs only at all-ones.
- cfg_load:
  - Sets both pointers to loop_start and clears pending and overrun flags.
  - A req in the same cycle is retained as pending.
  - A read already in flight still completes and delivers data, but its pointer advance is suppressed.
- enable falling mid-read: the current ISSUE/CAPTURE sequence completes; no further grants are made.

## Timing
- Latency from an idle block: req in cycle 0 → ISSUE (ram_rd_en, ram_addr valid) in cycle 1 → CAPTURE in cycle 2 → x_valid = 1 with x_data in cycle 3.
- Sustained throughput: one read every 2 cycles. ram_rd_en is never high in two consecutive cycles.
- x_valid is a single-cycle pulse. x_data is stable from the valid cycle until the next valid of the same channel.
- Asynchronous reset mid-read aborts the read; no valid pulse is issued after deassertion.
- ram_addr holds its value outside ISSUE.

## Test plan
- Basic fetch: after reset, loop_start = 0x0010, loop_end = 0x0012, cfg_load, then l_req. Required: ram_addr = 0x0010 with ram_rd_en one cycle later. l_valid 3 cycles after req, with l_data equal to the RAM model byte at 0x0010.
- Wrap: 4 l_req, each spaced 4 cycles apart, with the same window. Required addresses 0x0010, 0x0011, 0x0012, 0x0010.
- Simultaneous: l_req and r_req in the same cycle from reset. Required: left is read first, right is read 2 cycles later. Both pointers advance independently, with r_valid 2 cycles after l_valid.
- Overrun: enable = 0, l_req twice. Required: l_overrun = 1, and one read only after enable = 1. cfg_load then returns l_overrun to 0.
- cfg_load during CAPTURE of the right channel: r_valid still pulses, and the next right read uses loop_start, not an incremented pointer.
- Reset during ISSUE: all outputs return to 0 immediately, no valid follows, and the next l_req reads address 0.
